// File: rtl/evm_pkg.sv
// Shared definitions for the EVM ballot unit: FSM state encoding, index-width
// helper and the LED acknowledge pattern.
package evm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACK    = 2'd2,
    ST_RESULT = 2'd3
  } evm_state_t;

  // Wide all-ones source; the top slices it down to its own COUNT_W.
  localparam int LED_ACK_MAX_W = 32;
  localparam logic [LED_ACK_MAX_W-1:0] LED_ACK_ALL = {LED_ACK_MAX_W{1'b1}};

  function automatic int CAND_IDX_W(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-button debouncer: emits one press pulse after DEBOUNCE consecutive
// high samples and nothing more until the button has been released.
module button_debounce #(
  parameter int DEBOUNCE = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             press_r;

  // Saturating high-sample counter; the pulse fires only on the D-1 -> D step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else if (button) begin
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
      press_r <= (cnt_r == CNT_ARM);
    end else begin
      cnt_r   <= '0;
      press_r <= 1'b0;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/voting_machine_n.sv
// Parametrised ballot unit: one vote per authorisation, saturating tallies,
// registered leader/tie/total tracking and a result-mode tally display.
module voting_machine_n
  import evm_pkg::*;
#(
  parameter int N_CAND     = 4,
  parameter int COUNT_W    = 8,
  parameter int DEBOUNCE   = 10,
  parameter int ACK_CYCLES = 10,
  localparam int IDX_W     = CAND_IDX_W(N_CAND),
  localparam int TOT_W     = COUNT_W + IDX_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mode,
  input  logic               ballot_en,
  input  logic [N_CAND-1:0]  button,
  output logic [COUNT_W-1:0] led,
  output logic               ready,
  output logic [IDX_W-1:0]   winner,
  output logic               tie,
  output logic [TOT_W-1:0]   total,
  output logic               saturated
);

  localparam int HOLD_W = IDX_W + 1;
  localparam int ACK_W  = $clog2(ACK_CYCLES + 1);
  localparam logic [ACK_W-1:0]   ACK_LAST = ACK_W'(ACK_CYCLES - 1);
  localparam logic [COUNT_W-1:0] LED_ACK  = LED_ACK_ALL[COUNT_W-1:0];

  logic [N_CAND-1:0]  press_s;
  logic               press_any_s;
  logic [IDX_W-1:0]   pick_s;
  logic               full_s;
  logic               vote_s;

  evm_state_t         state_r;
  evm_state_t         state_nxt_s;
  logic [ACK_W-1:0]   ack_cnt_r;
  logic [COUNT_W-1:0] led_r;
  logic [COUNT_W-1:0] led_nxt_s;
  logic               ready_r;

  logic [COUNT_W-1:0] tally_r [N_CAND];

  logic [COUNT_W-1:0] max_s;
  logic [IDX_W-1:0]   lead_s;
  logic [HOLD_W-1:0]  holders_s;
  logic [TOT_W-1:0]   total_s;
  logic               sat_any_s;
  logic [IDX_W-1:0]   winner_r;
  logic               tie_r;
  logic [TOT_W-1:0]   total_r;
  logic               sat_r;

  for (genvar g = 0; g < N_CAND; g++) begin : g_deb
    button_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clock (clock),
      .reset (reset),
      .button(button[g]),
      .press (press_s[g])
    );
  end

  // Lowest-index press wins when several pulses coincide.
  always_comb begin
    pick_s = '0;
    for (int i = N_CAND - 1; i >= 0; i--) begin
      pick_s = press_s[i] ? IDX_W'(i) : pick_s;
    end
  end

  assign press_any_s = |press_s;
  assign full_s      = (tally_r[pick_s] == LED_ACK);

  // Next-state logic; mode=1 always takes priority and drops any authorisation.
  always_comb begin
    state_nxt_s = state_r;
    vote_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mode) begin
          state_nxt_s = ST_RESULT;
        end else if (ballot_en) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (mode) begin
          state_nxt_s = ST_RESULT;
        end else if (press_any_s) begin
          state_nxt_s = ST_ACK;
          vote_s      = 1'b1;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_ACK: begin
        if (mode) begin
          state_nxt_s = ST_RESULT;
        end else if (ack_cnt_r == ACK_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      ST_RESULT: begin
        if (!mode) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESULT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // LED follows the state being entered: ack pattern, cleared, or a tally readout.
  always_comb begin
    led_nxt_s = led_r;
    case (state_nxt_s)
      ST_ACK: begin
        led_nxt_s = LED_ACK;
      end
      ST_RESULT: begin
        if (state_r != ST_RESULT) begin
          led_nxt_s = '0;
        end else if (press_any_s) begin
          led_nxt_s = tally_r[pick_s];
        end else begin
          led_nxt_s = led_r;
        end
      end
      default: begin
        led_nxt_s = '0;
      end
    endcase
  end

  // Leader search: max first, then the lowest index holding it and the holder count.
  always_comb begin
    max_s     = '0;
    lead_s    = '0;
    holders_s = '0;
    total_s   = '0;
    sat_any_s = 1'b0;
    for (int i = 0; i < N_CAND; i++) begin
      max_s = (tally_r[i] > max_s) ? tally_r[i] : max_s;
    end
    for (int i = N_CAND - 1; i >= 0; i--) begin
      lead_s    = (tally_r[i] == max_s) ? IDX_W'(i) : lead_s;
      holders_s = holders_s + {{IDX_W{1'b0}}, (tally_r[i] == max_s)};
      total_s   = total_s + {{IDX_W{1'b0}}, tally_r[i]};
      sat_any_s = sat_any_s | (tally_r[i] == LED_ACK);
    end
  end

  // FSM state, ack timer and the registered LED/ready outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      ack_cnt_r <= '0;
      led_r     <= '0;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      led_r     <= led_nxt_s;
      ready_r   <= (state_nxt_s == ST_ARMED);
      if ((state_r == ST_ACK) && (state_nxt_s == ST_ACK)) begin
        ack_cnt_r <= ack_cnt_r + ACK_W'(1'b1);
      end else begin
        ack_cnt_r <= '0;
      end
    end
  end

  // Tallies; a vote on a full tally is still acknowledged but leaves it unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CAND; i++) begin
        tally_r[i] <= '0;
      end
    end else if (vote_s && !full_s) begin
      tally_r[pick_s] <= tally_r[pick_s] + COUNT_W'(1'b1);
    end else begin
      for (int i = 0; i < N_CAND; i++) begin
        tally_r[i] <= tally_r[i];
      end
    end
  end

  // Leader, tie, total and sticky saturation, one cycle behind the tallies.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      winner_r <= '0;
      tie_r    <= 1'b1;
      total_r  <= '0;
      sat_r    <= 1'b0;
    end else begin
      winner_r <= lead_s;
      tie_r    <= (holders_s > HOLD_W'(1'b1));
      total_r  <= total_s;
      sat_r    <= sat_r | sat_any_s;
    end
  end

  assign led       = led_r;
  assign ready     = ready_r;
  assign winner    = winner_r;
  assign tie       = tie_r;
  assign total     = total_r;
  assign saturated = sat_r;

endmodule
